bp_cce_pending_table: RTL and testbench

//  Per-block pending-transaction table for the CCE. Holds one saturating counter per hashed

---
 rtl/bp_cce_pkg.sv | 16 +
 rtl/bp_cce_pending_sat_ctr.sv | 43 ++++
 rtl/bp_cce_pending_table.sv | 104 ++++++++++
 tb/tb_bp_cce_pending_table.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE types: pending-table operation codes and sweep FSM states.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_pend_nop,
    e_pend_inc,
    e_pend_dec,
    e_pend_clr
  } bp_cce_pending_op_e;

  typedef enum logic [0:0] {
    e_init,
    e_ready
  } bp_cce_pending_state_e;

endpackage

// File: rtl/bp_cce_pending_sat_ctr.sv
// Combinational saturating counter step: next count plus overflow/underflow flags.
module bp_cce_pending_sat_ctr
  import bp_cce_pkg::*;
#(
  parameter int cnt_width_p = 4
) (
  input  logic [cnt_width_p-1:0] cnt_i,
  input  bp_cce_pending_op_e     op_i,
  output logic [cnt_width_p-1:0] cnt_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam logic [cnt_width_p-1:0] max_lp = '1;
  localparam logic [cnt_width_p-1:0] one_lp = {{(cnt_width_p-1){1'b0}}, 1'b1};

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] c);
    return (c == max_lp) ? c : c + one_lp;
  endfunction

  function automatic logic [cnt_width_p-1:0] sat_dec(input logic [cnt_width_p-1:0] c);
    return (c == '0) ? c : c - one_lp;
  endfunction

  always_comb begin
    cnt_o       = cnt_i;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    case (op_i)
      e_pend_inc: begin
        cnt_o      = sat_inc(cnt_i);
        overflow_o = (cnt_i == max_lp);
      end
      e_pend_dec: begin
        cnt_o       = sat_dec(cnt_i);
        underflow_o = (cnt_i == '0);
      end
      e_pend_clr: cnt_o = '0;
      default:    cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/bp_cce_pending_table.sv
// Per-block pending-transaction table: saturating counters indexed by hashed block address,
// cleared by a post-reset sweep, with a registered write-first pending lookup.
module bp_cce_pending_table
  import bp_cce_pkg::*;
#(
  parameter int paddr_width_p  = 40,
  parameter int block_offset_p = 6,
  parameter int num_entries_p  = 64,
  parameter int cnt_width_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     ready_o,
  input  logic                     w_v_i,
  input  logic [paddr_width_p-1:0] w_addr_i,
  input  logic [1:0]               w_op_i,
  input  logic                     r_v_i,
  input  logic [paddr_width_p-1:0] r_addr_i,
  output logic                     pending_v_o,
  output logic                     pending_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int lg_entries_lp = $clog2(num_entries_p);
  localparam logic [lg_entries_lp-1:0] last_idx_lp = '1;

  bp_cce_pending_state_e     state_r;
  logic [lg_entries_lp-1:0]  sweep_idx_r;
  logic [cnt_width_p-1:0]    cnt_r [num_entries_p];

  logic                      w_acc, r_acc;
  logic [lg_entries_lp-1:0]  w_idx, r_idx;
  bp_cce_pending_op_e        w_op;
  logic [cnt_width_p-1:0]    w_cnt_next, r_cnt_post;
  logic                      w_ovf, w_unf;

  logic                      vld_p1, pend_p1, ovf_p1, unf_p1;

  // Only the index field of each address selects a counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_i, r_addr_i};

  assign ready_o = (state_r == e_ready);
  assign w_acc   = w_v_i & ready_o;
  assign r_acc   = r_v_i & ready_o;
  assign w_idx   = w_addr_i[block_offset_p +: lg_entries_lp];
  assign r_idx   = r_addr_i[block_offset_p +: lg_entries_lp];
  assign w_op    = w_acc ? bp_cce_pending_op_e'(w_op_i) : e_pend_nop;

  bp_cce_pending_sat_ctr #(
    .cnt_width_p(cnt_width_p)
  ) sat_ctr (
    .cnt_i      (cnt_r[w_idx]),
    .op_i       (w_op),
    .cnt_o      (w_cnt_next),
    .overflow_o (w_ovf),
    .underflow_o(w_unf)
  );

  // Write-first: a same-index write in this cycle is visible to the read.
  assign r_cnt_post = (w_acc && (w_idx == r_idx)) ? w_cnt_next : cnt_r[r_idx];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_init;
      sweep_idx_r <= '0;
    end else if (state_r == e_init) begin
      sweep_idx_r <= sweep_idx_r + 1'b1;
      if (sweep_idx_r == last_idx_lp) state_r <= e_ready;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_r == e_init) begin
      cnt_r[sweep_idx_r] <= '0;
    end else if (w_acc) begin
      cnt_r[w_idx] <= w_cnt_next;
    end
  end

  // ---- stage p0 -> p1: registered lookup result and flag pulses ----
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      vld_p1 <= r_acc;
      ovf_p1 <= w_ovf;
      unf_p1 <= w_unf;
    end
  end

  always_ff @(posedge clk_i) begin
    pend_p1 <= (r_cnt_post != '0);
  end

  assign pending_v_o = vld_p1;
  assign pending_o   = vld_p1 & pend_p1;
  assign overflow_o  = ovf_p1;
  assign underflow_o = unf_p1;

endmodule

// File: tb/tb_bp_cce_pending_table.sv
// Directed self-checking bench for bp_cce_pending_table.
module tb_bp_cce_pending_table;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        ready_o;
  logic        w_v_i;
  logic [39:0] w_addr_i;
  logic [1:0]  w_op_i;
  logic        r_v_i;
  logic [39:0] r_addr_i;
  logic        pending_v_o, pending_o, overflow_o, underflow_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] NOP = 2'd0, INC = 2'd1, DEC = 2'd2, CLR = 2'd3;

  always #5 clk = ~clk;

  bp_cce_pending_table #(
    .paddr_width_p (40),
    .block_offset_p(6),
    .num_entries_p (64),
    .cnt_width_p   (4)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .ready_o    (ready_o),
    .w_v_i      (w_v_i),
    .w_addr_i   (w_addr_i),
    .w_op_i     (w_op_i),
    .r_v_i      (r_v_i),
    .r_addr_i   (r_addr_i),
    .pending_v_o(pending_v_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at negedge; outputs are sampled 1ns after the next posedge.
  task automatic step(input logic rst, input logic wv, input logic [39:0] wa, input logic [1:0] op,
                      input logic rv, input logic [39:0] ra);
    @(negedge clk);
    reset_i  = rst;
    w_v_i    = wv;
    w_addr_i = wa;
    w_op_i   = op;
    r_v_i    = rv;
    r_addr_i = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 40'h0, NOP, 1'b0, 40'h0);
  endtask

  task automatic wr(input logic [39:0] a, input logic [1:0] op);
    step(1'b0, 1'b1, a, op, 1'b0, 40'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [39:0] a, input logic exp);
    step(1'b0, 1'b0, 40'h0, NOP, 1'b1, a);
    chk({tag, "_v"}, {31'b0, pending_v_o}, 32'd1);
    chk(tag, {31'b0, pending_o}, {31'b0, exp});
  endtask

  // Reset for two edges, then count edges until ready; ready must rise on exactly the 64th.
  task automatic reset_and_sweep(input string tag);
    step(1'b1, 1'b0, 40'h0, NOP, 1'b0, 40'h0);
    step(1'b1, 1'b0, 40'h0, NOP, 1'b0, 40'h0);
    chk({tag, "_rst_ready"}, {31'b0, ready_o}, 32'd0);
    chk({tag, "_rst_pv"}, {31'b0, pending_v_o}, 32'd0);
    chk({tag, "_rst_ovf"}, {30'b0, overflow_o, underflow_o}, 32'd0);
    for (int n = 1; n <= 64; n++) begin
      // writes and reads offered during the sweep must be ignored
      step(1'b0, 1'b1, 40'h0, INC, 1'b1, 40'h0);
      if (n == 63) chk({tag, "_ready_63"}, {31'b0, ready_o}, 32'd0);
      if (n == 64) chk({tag, "_ready_64"}, {31'b0, ready_o}, 32'd1);
      if (n == 10) chk({tag, "_init_pv"}, {31'b0, pending_v_o}, 32'd0);
    end
  endtask

  initial begin
    reset_i = 1'b1; w_v_i = 1'b0; w_addr_i = '0; w_op_i = NOP; r_v_i = 1'b0; r_addr_i = '0;

    // 1: reset sweep and clean reads
    reset_and_sweep("t1");
    rd_chk("t1_rd0", 40'h0, 1'b0);
    rd_chk("t1_rd1000", 40'h1000, 1'b0);
    idle();
    chk("t1_idle_pv", {31'b0, pending_v_o}, 32'd0);
    chk("t1_idle_p", {31'b0, pending_o}, 32'd0);

    // 2: inc x3, dec x2 -> 1; dec -> 0; never a flag
    for (int i = 0; i < 3; i++) begin
      wr(40'h1000, INC);
      chk("t2_inc_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      wr(40'h1000, DEC);
      chk("t2_dec_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    end
    rd_chk("t2_rd_one", 40'h1000, 1'b1);
    wr(40'h1000, DEC);
    chk("t2_dec3_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    rd_chk("t2_rd_zero", 40'h1000, 1'b0);

    // 3: saturate at 15, overflow on the 16th inc only; clr then dec underflows
    for (int i = 1; i <= 16; i++) begin
      wr(40'h2040, INC);
      chk(i == 16 ? "t3_ovf16" : "t3_ovf_early", {31'b0, overflow_o}, (i == 16) ? 32'd1 : 32'd0);
    end
    idle();
    chk("t3_ovf_pulse_end", {31'b0, overflow_o}, 32'd0);
    rd_chk("t3_rd_sat", 40'h2040, 1'b1);
    wr(40'h2040, CLR);
    chk("t3_clr_flags", {30'b0, overflow_o, underflow_o}, 32'd0);
    wr(40'h2040, DEC);
    chk("t3_unf", {31'b0, underflow_o}, 32'd1);
    chk("t3_unf_noovf", {31'b0, overflow_o}, 32'd0);
    rd_chk("t3_rd_after", 40'h2040, 1'b0);
    chk("t3_unf_pulse_end", {31'b0, underflow_o}, 32'd0);

    // 4: same-cycle inc and read of a zero counter is write-first
    step(1'b0, 1'b1, 40'h3000, INC, 1'b1, 40'h3000);
    chk("t4_wf_v", {31'b0, pending_v_o}, 32'd1);
    chk("t4_wf", {31'b0, pending_o}, 32'd1);
    // same-cycle dec to zero and read: write-first gives 0
    step(1'b0, 1'b1, 40'h3000, DEC, 1'b1, 40'h3000);
    chk("t4_wf_dec", {31'b0, pending_o}, 32'd0);

    // 5: aliasing 0x0000 / 0x1000 share index 0; 0x0040 is index 1
    wr(40'h0000, INC);
    rd_chk("t5_alias", 40'h1000, 1'b1);
    rd_chk("t5_other", 40'h0040, 1'b0);
    // different-index write does not forward into the read
    step(1'b0, 1'b1, 40'h0080, INC, 1'b1, 40'h00C0);
    chk("t5_indep", {31'b0, pending_o}, 32'd0);
    rd_chk("t5_idx2", 40'h0080, 1'b1);

    // 6a: reset in the middle of the sweep
    step(1'b1, 1'b0, 40'h0, NOP, 1'b0, 40'h0);
    for (int n = 0; n < 30; n++) idle();
    chk("t6_mid_ready", {31'b0, ready_o}, 32'd0);
    reset_and_sweep("t6a");
    rd_chk("t6a_rd0", 40'h0, 1'b0);

    // 6b: reset in e_ready after incs, with a read in flight
    wr(40'h0000, INC);
    wr(40'h0140, INC);
    rd_chk("t6b_pre", 40'h0140, 1'b1);
    step(1'b1, 1'b0, 40'h0, NOP, 1'b1, 40'h0140);
    chk("t6b_drop_pv", {31'b0, pending_v_o}, 32'd0);
    chk("t6b_drop_ready", {31'b0, ready_o}, 32'd0);
    reset_and_sweep("t6b");
    rd_chk("t6b_rd0", 40'h0000, 1'b0);
    rd_chk("t6b_rd5", 40'h0140, 1'b0);
    rd_chk("t6b_rd2", 40'h0080, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
